udp_pkt_fifo: RTL and testbench

Parametrised synchronous packet FIFO for the UDP TX path. It is the successor of the plain byte FIFO. It stores data words together with an end-of-packet flag and exposes only fully committed packets to the reader. A packet can be discarded mid-write, either explicitly or automatically on overflow. It sits between the UDP payload assembler (write side) and the MAC/SFP framer (read side), which starts a frame only when rd_pkt_avail is high.

---
 rtl/udp_pkt_fifo_if.sv | 43 ++++
 rtl/udp_pkt_fifo.sv | 137 +++++++++++++
 tb/tb_udp_pkt_fifo.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkt_fifo_if.sv
// Write/read bus of the UDP TX packet FIFO.
// Handshake: a write beat is taken on a rising edge where wr_en=1 and
// wr_full=0, unless wr_drop is high in the same cycle, which wins. A read is
// taken on a rising edge where rd_en=1 and rd_empty=0; its word is presented
// with rd_valid=1 one cycle later, or two with the output register. rd_en
// while rd_empty is ignored. The reader has no backpressure on rd_data.
interface udp_pkt_fifo_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH_WIDTH   = 12,
  parameter int PKT_CNT_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_en;
  logic                     wr_last;
  logic                     wr_drop;
  logic                     wr_full;
  logic                     almost_full;
  logic [DEPTH_WIDTH:0]     wr_water_level;
  logic [15:0]              wr_drop_cnt;
  logic                     rd_en;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_last;
  logic                     rd_valid;
  logic                     rd_empty;
  logic                     almost_empty;
  logic [DEPTH_WIDTH:0]     rd_water_level;
  logic                     rd_pkt_avail;
  logic [PKT_CNT_WIDTH-1:0] rd_pkt_cnt;

  modport master (
    output wr_data, wr_en, wr_last, wr_drop, rd_en,
    input  wr_full, almost_full, wr_water_level, wr_drop_cnt,
           rd_data, rd_last, rd_valid, rd_empty, almost_empty,
           rd_water_level, rd_pkt_avail, rd_pkt_cnt
  );

  modport slave (
    input  wr_data, wr_en, wr_last, wr_drop, rd_en,
    output wr_full, almost_full, wr_water_level, wr_drop_cnt,
           rd_data, rd_last, rd_valid, rd_empty, almost_empty,
           rd_water_level, rd_pkt_avail, rd_pkt_cnt
  );
endinterface

// File: rtl/udp_pkt_fifo.sv
// Packet FIFO for the UDP TX path. Words are written speculatively behind
// wr_ptr and become visible to the reader only when the last word of the
// packet moves cm_ptr forward. A packet is thrown away on wr_drop or when
// its words overflowed the FIFO.
module udp_pkt_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 12,
  parameter int ALMOST_FULL_NUM  = 4094,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int PKT_CNT_WIDTH    = 8,
  parameter int OUTPUT_REG       = 0
) (
  input logic           clk,
  input logic           tb_rst,
  udp_pkt_fifo_if.slave bus
);
  localparam int PW = DEPTH_WIDTH + 1;
  localparam logic [PW-1:0] CAPACITY = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AF_LVL   = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LVL   = PW'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH:0]      mem [0:(1 << DEPTH_WIDTH)-1];
  logic [PW-1:0]            wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0]            wr_level, rd_level;
  logic                     ovf;
  logic [15:0]              drop_cnt;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt;
  logic [DATA_WIDTH-1:0]    s1_data, out_data;
  logic                     s1_last, s1_valid, out_last, out_valid;
  logic                     full, empty, discard, wr_accept, commit;
  logic                     rd_accept, pkt_done;

  // Levels, flags and per-cycle decisions from the registered pointers.
  // A last beat that finds ovf set, or that is itself refused because the
  // FIFO is full, ends a packet that lost words, so it is discarded.
  always_comb begin
    wr_level  = wr_ptr - rd_ptr;
    rd_level  = cm_ptr - rd_ptr;
    full      = (wr_level == CAPACITY);
    empty     = (cm_ptr == rd_ptr);
    discard   = bus.wr_drop || (bus.wr_en && bus.wr_last && (ovf || full));
    wr_accept = bus.wr_en && !full && !discard;
    commit    = wr_accept && bus.wr_last;
    rd_accept = bus.rd_en && !empty;
    pkt_done  = out_valid && out_last;
  end

  // Write side: speculative pointer, commit pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      ovf    <= 1'b0;
    end else if (discard) begin
      wr_ptr <= cm_ptr;
      ovf    <= 1'b0;
    end else if (bus.wr_en && full) begin
      ovf <= 1'b1;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (bus.wr_last) cm_ptr <= wr_ptr + 1'b1;
    end
  end

  // Storage array; the top bit carries the end-of-packet flag.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[DEPTH_WIDTH-1:0]] <= {bus.wr_last, bus.wr_data};
  end

  // Saturating count of discarded packets.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) drop_cnt <= '0;
    else if (discard && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end

  // Committed packets not yet fully presented to the reader.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) pkt_cnt <= '0;
    else if (commit && !pkt_done) pkt_cnt <= pkt_cnt + 1'b1;
    else if (!commit && pkt_done) pkt_cnt <= pkt_cnt - 1'b1;
  end

  // Read pointer and first output stage; data holds while nothing is read.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rd_ptr   <= '0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        rd_ptr             <= rd_ptr + 1'b1;
        {s1_last, s1_data} <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      // Optional second output stage for timing; adds one cycle of latency.
      always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
          out_data  <= '0;
          out_last  <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_data <= s1_data;
            out_last <= s1_last;
          end
        end
      end
    end else begin : g_no_out_reg
      // Present the first stage directly.
      always_comb begin
        out_data  = s1_data;
        out_last  = s1_last;
        out_valid = s1_valid;
      end
    end
  endgenerate

  assign bus.wr_full        = full;
  assign bus.almost_full    = (wr_level >= AF_LVL);
  assign bus.wr_water_level = wr_level;
  assign bus.wr_drop_cnt    = drop_cnt;
  assign bus.rd_data        = out_data;
  assign bus.rd_last        = out_last;
  assign bus.rd_valid       = out_valid;
  assign bus.rd_empty       = empty;
  assign bus.almost_empty   = (rd_level <= AE_LVL);
  assign bus.rd_water_level = rd_level;
  assign bus.rd_pkt_avail   = (pkt_cnt != '0);
  assign bus.rd_pkt_cnt     = pkt_cnt;
endmodule

// File: tb/tb_udp_pkt_fifo.sv
// Bench for udp_pkt_fifo. Two small FIFOs (16 entries, output register off
// and on) share one stimulus stream and one packet-level reference model;
// a default-size FIFO covers the 4096-word packet.
module tb_udp_pkt_fifo;
  localparam int D_S = 16;
  localparam logic [127:0] RST_EXP_S = 128'({7'b0011000, 38'd0});
  localparam logic [127:0] RST_EXP_C = 128'({7'b0011000, 58'd0});

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic tb_rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUTs ----------------
  udp_pkt_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .PKT_CNT_WIDTH(4)) bus_a ();
  udp_pkt_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .PKT_CNT_WIDTH(4)) bus_b ();
  udp_pkt_fifo_if bus_c ();

  logic [7:0] wr_data;
  logic       wr_en, wr_last, wr_drop, rd_en;
  logic [7:0] c_wr_data;
  logic       c_wr_en, c_wr_last, c_rd_en;

  assign bus_a.wr_data = wr_data;  assign bus_b.wr_data = wr_data;
  assign bus_a.wr_en   = wr_en;    assign bus_b.wr_en   = wr_en;
  assign bus_a.wr_last = wr_last;  assign bus_b.wr_last = wr_last;
  assign bus_a.wr_drop = wr_drop;  assign bus_b.wr_drop = wr_drop;
  assign bus_a.rd_en   = rd_en;    assign bus_b.rd_en   = rd_en;
  assign bus_c.wr_data = c_wr_data;
  assign bus_c.wr_en   = c_wr_en;
  assign bus_c.wr_last = c_wr_last;
  assign bus_c.wr_drop = 1'b0;
  assign bus_c.rd_en   = c_rd_en;

  udp_pkt_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                 .ALMOST_EMPTY_NUM(2), .PKT_CNT_WIDTH(4), .OUTPUT_REG(0))
    u_dut_a (.clk(clk), .tb_rst(tb_rst), .bus(bus_a));
  udp_pkt_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                 .ALMOST_EMPTY_NUM(2), .PKT_CNT_WIDTH(4), .OUTPUT_REG(1))
    u_dut_b (.clk(clk), .tb_rst(tb_rst), .bus(bus_b));
  udp_pkt_fifo u_dut_c (.clk(clk), .tb_rst(tb_rst), .bus(bus_c));

  // ---------------- reference model (packet level) ----------------
  logic [8:0] m_comm[$];   // committed words not yet read
  logic [8:0] m_part[$];   // words of the packet being written
  bit         m_ovf;
  int         m_drops, m_pkts_a, m_pkts_b;
  bit         lq_a[$], lq_b[$], vq_b[$];
  logic [8:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_comm.delete(); m_part.delete();
    m_ovf = 0; m_drops = 0; m_pkts_a = 0; m_pkts_b = 0;
    lq_a.delete(); lq_b.delete(); vq_b.delete();
    lq_a.push_back(1'b0);
    lq_b.push_back(1'b0); lq_b.push_back(1'b0);
    vq_b.push_back(1'b0);
    exp_q_a.delete(); exp_q_b.delete();
  endtask

  task automatic check_ab(input bit ev_a, input bit ev_b);
    int lw, lr;
    lw = m_comm.size() + m_part.size();
    lr = m_comm.size();
    check("a_wr_level", 128'(bus_a.wr_water_level), 128'(lw));
    check("a_rd_level", 128'(bus_a.rd_water_level), 128'(lr));
    check("a_flags", 128'({bus_a.wr_full, bus_a.almost_full, bus_a.rd_empty, bus_a.almost_empty,
                           bus_a.rd_pkt_avail, bus_a.rd_valid}),
          128'({lw == D_S, lw >= 14, lr == 0, lr <= 2, m_pkts_a != 0, ev_a}));
    check("a_drop_cnt", 128'(bus_a.wr_drop_cnt), 128'(m_drops));
    check("a_pkt_cnt", 128'(bus_a.rd_pkt_cnt), 128'(m_pkts_a));
    check("b_levels", 128'({bus_b.wr_water_level, bus_b.rd_water_level}), 128'({5'(lw), 5'(lr)}));
    check("b_flags", 128'({bus_b.wr_full, bus_b.almost_full, bus_b.rd_empty, bus_b.almost_empty,
                           bus_b.rd_pkt_avail, bus_b.rd_valid}),
          128'({lw == D_S, lw >= 14, lr == 0, lr <= 2, m_pkts_b != 0, ev_b}));
    check("b_drop_cnt", 128'(bus_b.wr_drop_cnt), 128'(m_drops));
    check("b_pkt_cnt", 128'(bus_b.rd_pkt_cnt), 128'(m_pkts_b));
  endtask

  // ---------------- driver: one clock of stimulus for DUTs a/b ----------------
  task automatic step(input bit we, input bit wl, input bit wd, input logic [7:0] d, input bit re);
    bit full, rd_ok, commit, dec_a, dec_b, ev_b;
    logic [8:0] w;
    wr_en = we; wr_last = wl; wr_drop = wd; wr_data = d; rd_en = re;
    w      = '0;
    full   = (m_comm.size() + m_part.size()) == D_S;
    rd_ok  = re && m_comm.size() != 0;
    commit = 0;
    if (wd || (we && wl && (m_ovf || full))) begin
      m_part.delete();
      m_ovf = 0;
      if (m_drops < 65535) m_drops++;
    end else if (we && full) begin
      m_ovf = 1;
    end else if (we) begin
      m_part.push_back({wl, d});
      if (wl) begin
        foreach (m_part[i]) m_comm.push_back(m_part[i]);
        m_part.delete();
        commit = 1;
      end
    end
    if (rd_ok) begin
      w = m_comm.pop_front();
      exp_q_a.push_back(w);
      exp_q_b.push_back(w);
    end
    lq_a.push_back(rd_ok && w[8]); dec_a = lq_a.pop_front();
    lq_b.push_back(rd_ok && w[8]); dec_b = lq_b.pop_front();
    vq_b.push_back(rd_ok);         ev_b  = vq_b.pop_front();
    m_pkts_a = m_pkts_a + int'(commit) - int'(dec_a);
    m_pkts_b = m_pkts_b + int'(commit) - int'(dec_b);
    @(posedge clk); #1;
    check_ab(rd_ok, ev_b);
  endtask

  task automatic write_pkt(input int n, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < n; i++) step(1, with_last && (i == n - 1), 0, base + 8'(i), 0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 1);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_a
    logic [8:0] w;
    if (tb_rst === 1'b0 && bus_a.rd_valid === 1'b1) begin
      if (exp_q_a.size() == 0) check("a_rd_unexpected", 128'({bus_a.rd_last, bus_a.rd_data}), 128'h1_0000);
      else begin
        w = exp_q_a.pop_front();
        check("a_rd_word", 128'({bus_a.rd_last, bus_a.rd_data}), 128'(w));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [8:0] w;
    if (tb_rst === 1'b0 && bus_b.rd_valid === 1'b1) begin
      if (exp_q_b.size() == 0) check("b_rd_unexpected", 128'({bus_b.rd_last, bus_b.rd_data}), 128'h1_0000);
      else begin
        w = exp_q_b.pop_front();
        check("b_rd_word", 128'({bus_b.rd_last, bus_b.rd_data}), 128'(w));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [8:0] w;
    if (tb_rst === 1'b0 && bus_c.rd_valid === 1'b1) begin
      if (exp_q_c.size() == 0) check("c_rd_unexpected", 128'({bus_c.rd_last, bus_c.rd_data}), 128'h1_0000);
      else begin
        w = exp_q_c.pop_front();
        check("c_rd_word", 128'({bus_c.rd_last, bus_c.rd_data}), 128'(w));
      end
    end
  end

  // Hang guard.
  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_all();
    check("a_reset", 128'({bus_a.wr_full, bus_a.almost_full, bus_a.rd_empty, bus_a.almost_empty,
                           bus_a.rd_pkt_avail, bus_a.rd_valid, bus_a.rd_last, bus_a.rd_data,
                           bus_a.wr_water_level, bus_a.rd_water_level, bus_a.wr_drop_cnt,
                           bus_a.rd_pkt_cnt}), RST_EXP_S);
    check("b_reset", 128'({bus_b.wr_full, bus_b.almost_full, bus_b.rd_empty, bus_b.almost_empty,
                           bus_b.rd_pkt_avail, bus_b.rd_valid, bus_b.rd_last, bus_b.rd_data,
                           bus_b.wr_water_level, bus_b.rd_water_level, bus_b.wr_drop_cnt,
                           bus_b.rd_pkt_cnt}), RST_EXP_S);
    check("c_reset", 128'({bus_c.wr_full, bus_c.almost_full, bus_c.rd_empty, bus_c.almost_empty,
                           bus_c.rd_pkt_avail, bus_c.rd_valid, bus_c.rd_last, bus_c.rd_data,
                           bus_c.wr_water_level, bus_c.rd_water_level, bus_c.wr_drop_cnt,
                           bus_c.rd_pkt_cnt}), RST_EXP_C);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit we, wl, wd, re;
    int rp;
    tb_rst = 1'b1;
    wr_en = 0; wr_last = 0; wr_drop = 0; wr_data = '0; rd_en = 0;
    c_wr_en = 0; c_wr_last = 0; c_wr_data = '0; c_rd_en = 0;
    model_reset();
    #12;
    check_reset_all();
    #8 tb_rst = 1'b0;
    @(posedge clk); #1;

    // 1: a 5-word packet becomes visible only after its last word
    write_pkt(5, 8'h10, 1);
    read_n(5);
    idle_n(3);

    // 2: explicit drop of a partial packet, then a clean 2-word packet
    write_pkt(3, 8'h20, 0);
    step(0, 0, 1, 8'h00, 0);
    write_pkt(2, 8'h30, 1);
    read_n(2);
    idle_n(3);
    step(0, 0, 1, 8'h00, 0);    // drop with nothing pending
    step(1, 1, 1, 8'h55, 0);    // drop beats a same-cycle last write

    // 3: overflow of an unterminated packet, dropped by the next last beat
    write_pkt(16, 8'h40, 0);
    step(1, 0, 0, 8'h50, 0);
    step(1, 1, 0, 8'h51, 0);
    idle_n(2);

    // full boundary: a read frees a slot but the same-cycle write is refused
    write_pkt(16, 8'h60, 1);
    step(1, 0, 0, 8'h70, 1);
    step(1, 1, 0, 8'h71, 0);
    read_n(16);
    idle_n(3);

    // 4: read packet A while packet B is being written
    write_pkt(8, 8'h80, 1);
    for (int i = 0; i < 8; i++) step(i < 6, i == 5, 0, 8'h90 + 8'(i), 1);
    read_n(6);
    idle_n(3);

    // 5: reads on an empty FIFO are ignored; async reset mid-packet
    read_n(3);
    write_pkt(4, 8'hA0, 1);
    write_pkt(3, 8'hB0, 0);
    wr_en = 0; wr_last = 0; rd_en = 0;
    tb_rst = 1'b1;
    model_reset();
    #1;
    check_reset_all();
    #2 tb_rst = 1'b0;
    @(posedge clk); #1;

    // 6: back-to-back read of a 4-word packet (latency covered by DUT b)
    write_pkt(4, 8'hC0, 1);
    read_n(4);
    idle_n(3);

    // randomized traffic at three read rates
    for (int ph = 0; ph < 3; ph++) begin
      rp = 30 + 30 * ph;
      for (int i = 0; i < 250; i++) begin
        we = $urandom_range(0, 9) < 7;
        wl = ($urandom_range(0, 5) == 0) && (m_pkts_b < 14);
        wd = $urandom_range(0, 39) == 0;
        re = $urandom_range(0, 99) < rp;
        step(we, wl, wd, 8'($urandom), re);
      end
    end
    step(0, 0, 1, 8'h00, 0);
    read_n(20);
    idle_n(3);
    check("a_exp_drained", 128'(exp_q_a.size()), 128'd0);
    check("b_exp_drained", 128'(exp_q_b.size()), 128'd0);

    // 7: default-size FIFO filled by one 4096-word packet
    c_wr_en = 1;
    for (int i = 0; i < 4096; i++) begin
      c_wr_data = 8'($urandom);
      c_wr_last = (i == 4095);
      exp_q_c.push_back({c_wr_last, c_wr_data});
      @(posedge clk); #1;
      if (i == 4093)
        check("c_near_full", 128'({bus_c.wr_full, bus_c.almost_full, bus_c.rd_empty}), 128'b011);
    end
    c_wr_en = 0; c_wr_last = 0;
    check("c_full", 128'({bus_c.wr_full, bus_c.rd_empty, bus_c.rd_pkt_cnt}), 128'({2'b10, 8'd1}));
    check("c_levels", 128'({bus_c.wr_water_level, bus_c.rd_water_level}), 128'({13'd4096, 13'd4096}));
    c_rd_en = 1;
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("c_full_release", 128'(bus_c.wr_full), 128'd0);
    end
    c_rd_en = 0;
    repeat (3) begin @(posedge clk); #1; end
    check("c_drained", 128'({bus_c.rd_empty, bus_c.rd_pkt_cnt, bus_c.wr_water_level}), 128'({1'b1, 8'd0, 13'd0}));
    check("c_exp_drained", 128'(exp_q_c.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
